// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multicycle fetch/load/store sequencer in front of the unified memory
//
// Purpose:
//   Arbitrates between instruction-fetch and data load/store requests, runs
//   each accepted access as a fixed ACCESS -> RESP two-cycle sequence against a
//   memory with combinational read data, and latches read results into the
//   Instruction Register (IR) and Memory Data Register (MDR).
//
// Ports:
//   Clk, Reset_n                  clock, synchronous active-low reset
//   FetchReq/FetchAddr            fetch request (held until FetchGnt)
//   FetchGnt, Instr, InstrValid   fetch accept pulse, IR contents, IR-updated pulse
//   DataReq/DataWe/DataAddr/
//   DataWData                     load/store request (held until DataGnt)
//   DataGnt, DataRData, DataValid data accept pulse, MDR contents, done pulse
//   AddrErr                       out-of-range flag, pulses with the Valid
//   Busy                          sequencer not idle
//   MemAddress/MemWriteData/
//   MemWriteEnable, MemData       memory-side address, write port, read data

module mem_access_unit #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          Clk,
  input  logic          Reset_n,

  input  logic          FetchReq,
  input  logic [AW-1:0] FetchAddr,
  output logic          FetchGnt,
  output logic [DW-1:0] Instr,
  output logic          InstrValid,

  input  logic          DataReq,
  input  logic          DataWe,
  input  logic [AW-1:0] DataAddr,
  input  logic [DW-1:0] DataWData,
  output logic          DataGnt,
  output logic [DW-1:0] DataRData,
  output logic          DataValid,

  output logic          AddrErr,
  output logic          Busy,

  output logic [AW-1:0] MemAddress,
  output logic [DW-1:0] MemWriteData,
  output logic          MemWriteEnable,
  input  logic [DW-1:0] MemData
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_data;      // 1 = data access, 0 = fetch
  logic          acc_we;        // data access is a store
  logic          acc_oor;       // address was >= DEPTH at accept time
  logic          last_was_data; // winner of the most recent conflict
  logic [DW-1:0] ir;
  logic [DW-1:0] mdr;

  logic arb_point;
  logic any_req;
  logic conflict;
  logic win_data;
  logic fetch_oor;
  logic data_oor;

  // Arbitration only feeds register inputs; no request input reaches an
  // output port combinationally.
  assign arb_point = (state == IDLE) || (state == RESP);
  assign any_req   = FetchReq || DataReq;
  assign conflict  = FetchReq && DataReq;
  // On a conflict the side that lost the previous conflict wins; the flag
  // resets to 0 so the first conflict after reset goes to data.
  assign win_data  = conflict ? !last_was_data : DataReq;
  assign fetch_oor = (FetchAddr >= AW'(DEPTH));
  assign data_oor  = (DataAddr  >= AW'(DEPTH));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state         <= IDLE;
      acc_addr      <= '0;
      acc_wdata     <= '0;
      acc_data      <= 1'b0;
      acc_we        <= 1'b0;
      acc_oor       <= 1'b0;
      last_was_data <= 1'b0;
      ir            <= '0;
      mdr           <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (arb_point && any_req) begin
            state    <= ACCESS;
            acc_data <= win_data;
            acc_we   <= win_data && DataWe;
            acc_addr <= win_data ? DataAddr : FetchAddr;
            acc_oor  <= win_data ? data_oor : fetch_oor;
            // Write data only matters for stores; keep it clean otherwise.
            acc_wdata <= (win_data && DataWe) ? DataWData : '0;
            if (conflict) begin
              last_was_data <= win_data;
            end
          end else begin
            state <= IDLE;
          end
        end

        ACCESS: begin
          state <= RESP;
          // Out-of-range reads return zero instead of whatever the memory
          // drives for an unmapped address.
          if (!acc_data) begin
            ir <= acc_oor ? '0 : MemData;
          end else if (!acc_we) begin
            mdr <= acc_oor ? '0 : MemData;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic in_access;
  logic in_resp;
  logic store_access;

  assign in_access    = (state == ACCESS);
  assign in_resp      = (state == RESP);
  assign store_access = acc_data && acc_we;

  assign FetchGnt   = in_access && !acc_data;
  assign DataGnt    = in_access &&  acc_data;
  assign InstrValid = in_resp   && !acc_data;
  assign DataValid  = in_resp   &&  acc_data;
  assign AddrErr    = in_resp   &&  acc_oor;
  assign Busy       = (state != IDLE);

  assign Instr     = ir;
  assign DataRData = mdr;

  // Memory-side signals are parked at zero outside the ACCESS cycle; the
  // write strobe exists only for the single ACCESS edge of an in-range store.
  assign MemAddress     = in_access ? acc_addr : '0;
  assign MemWriteData   = (in_access && store_access) ? acc_wdata : '0;
  assign MemWriteEnable = in_access && store_access && !acc_oor;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit

module tb_mem_access_unit;

  logic        Clk;
  logic        Reset_n;
  logic        FetchReq;
  logic [31:0] FetchAddr;
  logic        FetchGnt;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        DataReq;
  logic        DataWe;
  logic [31:0] DataAddr;
  logic [31:0] DataWData;
  logic        DataGnt;
  logic [31:0] DataRData;
  logic        DataValid;
  logic        AddrErr;
  logic        Busy;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic [31:0] MemData;

  mem_access_unit #(.DEPTH(1024), .AW(32), .DW(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt),
    .Instr(Instr), .InstrValid(InstrValid),
    .DataReq(DataReq), .DataWe(DataWe), .DataAddr(DataAddr), .DataWData(DataWData),
    .DataGnt(DataGnt), .DataRData(DataRData), .DataValid(DataValid),
    .AddrErr(AddrErr), .Busy(Busy),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWriteEnable(MemWriteEnable), .MemData(MemData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Environment memory: combinational read, single-edge write. Unmapped
  // addresses return a non-zero pattern so zero-fill is observable.
  logic [31:0] mem [1024];
  int          wr_count;
  assign MemData = (MemAddress < 32'd1024) ? mem[MemAddress[9:0]] : 32'hDEADBEEF;
  always @(posedge Clk) begin
    if (MemWriteEnable) begin
      if (MemAddress < 32'd1024) mem[MemAddress[9:0]] <= MemWriteData;
      wr_count <= wr_count + 1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [1024];
  logic [31:0] m_ir;
  logic [31:0] m_mdr;
  bit          m_last_d;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present the given requests and serve them to completion, checking every
  // grant and response cycle against the model.
  task automatic run_pair(input bit rf, input logic [31:0] fa,
                          input bit rd, input bit we, input logic [31:0] da,
                          input logic [31:0] wd);
    bit          pf, pd, wdat, oor, store;
    logic [31:0] addr, val;
    int          wc0;
    FetchReq = rf; FetchAddr = fa;
    DataReq = rd; DataWe = we; DataAddr = da; DataWData = wd;
    pf = rf; pd = rd;
    while (pf || pd) begin
      tick();
      if (pf && pd) begin
        wdat = !m_last_d;
        m_last_d = wdat;
      end else begin
        wdat = pd;
      end
      addr  = wdat ? da : fa;
      oor   = (addr >= 32'd1024);
      store = wdat && we;
      chk("gnt_data", DataGnt, wdat);
      chk("gnt_fetch", FetchGnt, !wdat);
      chk("acc_addr", MemAddress, addr);
      chk("acc_we", MemWriteEnable, store && !oor);
      chk("acc_wdata", MemWriteData, store ? wd : 32'h0);
      chk("acc_busy", Busy, 1'b1);
      wc0 = wr_count;
      if (wdat) begin DataReq = 0; pd = 0; end
      else begin FetchReq = 0; pf = 0; end
      val = oor ? 32'h0 : ref_mem[addr[9:0]];
      if (store) begin
        if (!oor) ref_mem[addr[9:0]] = wd;
      end else if (wdat) begin
        m_mdr = val;
      end else begin
        m_ir = val;
      end
      tick();
      chk("valid_instr", InstrValid, !wdat);
      chk("valid_data", DataValid, wdat);
      chk("addr_err", AddrErr, oor);
      chk("instr", Instr, m_ir);
      chk("rdata", DataRData, m_mdr);
      chk("resp_we", MemWriteEnable, 1'b0);
      chk("resp_addr", MemAddress, 32'h0);
      chk("write_count", wr_count - wc0, (store && !oor) ? 1 : 0);
    end
    tick();
    chk("idle_busy", Busy, 1'b0);
    chk("idle_gnt", {FetchGnt, DataGnt, InstrValid, DataValid}, 4'h0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_words [3];
    checks = 0; errors = 0; wr_count = 0;
    m_ir = 0; m_mdr = 0; m_last_d = 0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] = v; ref_mem[i] = v;
    end
    mem[128] = 32'h8c030000; ref_mem[128] = 32'h8c030000;
    mem[132] = 32'h8c040001; ref_mem[132] = 32'h8c040001;
    mem[136] = 32'h8c050002; ref_mem[136] = 32'h8c050002;
    mem[1]   = 32'h00000001; ref_mem[1]   = 32'h00000001;
    exp_words[0] = 32'h8c030000;
    exp_words[1] = 32'h8c040001;
    exp_words[2] = 32'h8c050002;

    Reset_n = 0; FetchReq = 0; FetchAddr = 0;
    DataReq = 0; DataWe = 0; DataAddr = 0; DataWData = 0;
    tick(); tick();
    Reset_n = 1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_rdata", DataRData, 32'h0);
    chk("rst_pulses", {FetchGnt, DataGnt, InstrValid, DataValid, AddrErr, MemWriteEnable}, 6'h0);
    chk("rst_maddr", MemAddress, 32'h0);

    // Fetch 128
    run_pair(1, 32'd128, 0, 0, 0, 0);
    chk("fetch128_instr", Instr, 32'h8c030000);

    // Store 0x15 to 6, then load it back
    run_pair(0, 0, 1, 1, 32'd6, 32'h00000015);
    run_pair(0, 0, 1, 0, 32'd6, 0);
    chk("load6_rdata", DataRData, 32'h00000015);

    // Conflicts: first goes to data, the next one to fetch
    run_pair(1, 32'd132, 1, 0, 32'd1, 0);
    chk("conflict1_rdata", DataRData, 32'h00000001);
    chk("conflict1_instr", Instr, 32'h8c040001);
    run_pair(1, 32'd128, 1, 0, 32'd6, 0);

    // Out of range
    run_pair(0, 0, 1, 0, 32'd1024, 0);
    chk("oor_rdata", DataRData, 32'h0);
    run_pair(0, 0, 1, 1, 32'd2000, 32'hA5A5A5A5);
    run_pair(1, 32'hFFFF0000, 0, 0, 0, 0);

    // Reset during the ACCESS cycle of a load
    run_pair(0, 0, 1, 0, 32'd128, 0);
    DataReq = 1; DataWe = 0; DataAddr = 32'd6;
    tick();
    chk("midrst_gnt", DataGnt, 1'b1);
    Reset_n = 0; DataReq = 0;
    tick();
    m_ir = 0; m_mdr = 0; m_last_d = 0;
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_valid", DataValid, 1'b0);
    chk("midrst_rdata", DataRData, 32'h0);
    chk("midrst_instr", Instr, 32'h0);
    Reset_n = 1;
    tick();
    chk("midrst_valid2", DataValid, 1'b0);

    // Back-to-back fetches with FetchReq held
    FetchReq = 1; FetchAddr = 32'd128;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_gnt", FetchGnt, 1'b1);
      chk("b2b_addr", MemAddress, 32'd128 + 32'(4 * k));
      if (k < 2) FetchAddr = 32'd132 + 32'(4 * k);
      else FetchReq = 0;
      tick();
      chk("b2b_valid", InstrValid, 1'b1);
      chk("b2b_instr", Instr, exp_words[k]);
    end
    m_ir = 32'h8c050002;
    tick();
    chk("b2b_idle", Busy, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      bit          rf, rd, we;
      logic [31:0] fa, da, wd;
      rf = 1'($urandom_range(0, 1));
      rd = rf ? 1'($urandom_range(0, 1)) : 1'b1;
      we = 1'($urandom_range(0, 1));
      fa = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 4095)) : 32'($urandom_range(0, 1023));
      da = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 4095)) : 32'($urandom_range(0, 1023));
      wd = $urandom;
      run_pair(rf, fa, rd, we, da, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
